tx_byte_sched: RTL and testbench
================================

TX_BYTE_SCHED -- requirements
Module: tx_byte_sched

Interface
REQ-001 The block SHALL have a parameter BUSY_TIMEOUT, default 255: the number of cycles to wait for tx_busy to rise after tx_start.
REQ-002 The block SHALL have a parameter TW, default 8: the width of the timeout counter (BUSY_TIMEOUT < 2^TW).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 The block SHALL have port clk, input, 1 bit: system clock, rising-edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 The block SHALL have port en, input, 1 bit: when 0, no new grants; an in-flight transfer completes.
REQ-007 The block SHALL have port req, input, 8 bits: req[i]=1 means byte source i has a byte to send.
REQ-008 The block SHALL have port tx_busy, input, 1 bit: UART transmitter busy.
REQ-009 The block SHALL have port sel, output, 3 bits: select to the 8:1 byte mux feeding the UART data input.
REQ-010 The block SHALL have port tx_start, output, 1 bit: one-cycle start strobe to the UART.
REQ-011 The block SHALL have port ack, output, 8 bits: one-hot, one-cycle pulse that the selected source's byte was taken.
REQ-012 The block SHALL have port active, output, 1 bit: 1 whenever state != IDLE.
REQ-013 The block SHALL have port err, output, 1 bit: one-cycle pulse on busy timeout.

Function
REQ-014 The block SHALL implement states IDLE, LOAD, WAIT_BUSY and WAIT_DONE.
REQ-015 IDLE SHALL go to LOAD when en=1, req!=0 and tx_busy=0; on that edge sel<=winner and ptr<=winner+1 (mod 8, so 7 wraps to 0).
REQ-016 The winner SHALL be the first set req bit searching upward from ptr, modulo 8.
REQ-017 LOAD SHALL last exactly one cycle, with tx_start=1 and ack[sel]=1 during it, then go to WAIT_BUSY.
REQ-018 tx_start and ack SHALL be 0 in every state other than LOAD.
REQ-019 WAIT_BUSY SHALL go to WAIT_DONE when tx_busy=1.
REQ-020 In WAIT_BUSY, if the cycle counter reaches BUSY_TIMEOUT with tx_busy still 0, the block SHALL pulse err for 1 cycle and return to IDLE.
REQ-021 The counter SHALL clear on entry to WAIT_BUSY and saturate; it SHALL never wrap.
REQ-022 WAIT_DONE SHALL go to IDLE when tx_busy=0.
REQ-023 sel SHALL hold constant from LOAD through WAIT_DONE; it SHALL change only on the IDLE->LOAD edge.
REQ-024 Latency SHALL be: req asserted in IDLE -> tx_start 1 cycle later; minimum per-byte cycle is 4 clocks plus UART busy time.
REQ-025 Deasserting req[sel] after LOAD SHALL NOT abort the transfer; changes to req or en outside IDLE SHALL be ignored.
REQ-026 If tx_busy=1 while in IDLE, no grant SHALL be issued until it falls.
REQ-027 When en falls mid-transfer, the transfer SHALL complete and the block SHALL then stay in IDLE.
REQ-028 All outputs SHALL be registered or decoded purely from state, with no combinational path from req to outputs.

Reset
REQ-029 Reset SHALL set state=IDLE, sel=0, ptr=0, counter=0, tx_start=0, ack=0, active=0, err=0 asynchronously.
REQ-030 Reset asserted mid-transfer SHALL abandon the transfer; no ack or tx_start pulse is issued after reset release until a new IDLE->LOAD.

Structure
REQ-031 A shared package SHALL hold the state encoding constants (2 bits) and NSRC=8.
REQ-032 The round-robin search SHALL be one sub-module, rr_pick8 (inputs req[7:0] and ptr[2:0]; outputs winner[2:0] and any), purely combinational.
REQ-033 sel SHALL connect directly to the existing 8:1 byte mux select.

Verification
REQ-034 Reset, then req=8'b0000_0001 with tx_busy=0 -> tx_start and ack=8'h01 one cycle later, sel=0; model UART busy for 10 cycles -> return to IDLE, active=0.
REQ-035 With req=8'hFF held and a UART model -> grants in order sel=0,1,...,7,0 (wrap checked), each ack one-hot.
REQ-036 After grants to 5 and 6, req=8'b0010_0001 -> next grant sel=0 (search from ptr=7 wraps), then sel=5.
REQ-037 tx_busy never rises, BUSY_TIMEOUT=255 -> err pulses exactly once, 256 cycles after tx_start, then return to IDLE.
REQ-038 en=0 asserted during WAIT_DONE with req=8'h0F -> the transfer finishes and no further tx_start occurs while en=0.
REQ-039 rst pulsed in WAIT_BUSY -> all outputs 0 immediately, ptr=0, and the next grant starts from source 0.

Source files
------------

// File: rtl/tx_byte_sched_pkg.sv
// rtl/tx_byte_sched_pkg.sv - shared constants and state encoding for the UART byte scheduler
package tx_byte_sched_pkg;

  localparam int NSRC = 8;
  localparam int SELW = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/tx_byte_sched_rr_pick8.sv
// rtl/tx_byte_sched_rr_pick8.sv - combinational round-robin pick of the first set req bit at or above ptr
module rr_pick8
  import tx_byte_sched_pkg::*;
(
  input  logic [NSRC-1:0] req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] winner,
  output logic            any
);

  logic [SELW-1:0] idx;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    // 3-bit index arithmetic wraps the search past source 7 back to 0
    for (int i = 0; i < NSRC; i++) begin
      idx = ptr + SELW'(i);
      if (!any && req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_byte_sched.sv
// rtl/tx_byte_sched.sv - round-robin scheduler granting one byte source at a time to a UART transmitter
module tx_byte_sched
  import tx_byte_sched_pkg::*;
#(
  parameter int BUSY_TIMEOUT = 255,
  parameter int TW           = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NSRC-1:0] req,
  input  logic            tx_busy,
  output logic [SELW-1:0] sel,
  output logic            tx_start,
  output logic [NSRC-1:0] ack,
  output logic            active,
  output logic            err
);

  localparam logic [TW:0] TIMEOUT_L = (TW+1)'(BUSY_TIMEOUT);

  state_e          state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;

  logic [SELW-1:0] pick_winner;
  logic            pick_any;
  logic [TW:0]     cnt_inc;

  rr_pick8 u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (pick_winner),
    .any    (pick_any)
  );

  assign cnt_inc = {1'b0, cnt_q} + (TW+1)'(1);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en && pick_any && !tx_busy) begin
          state_d = ST_LOAD;
          sel_d   = pick_winner;
          ptr_d   = pick_winner + SELW'(1);
        end
      end
      ST_LOAD: begin
        state_d = ST_WAIT_BUSY;
        cnt_d   = '0;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else begin
          cnt_d = (&cnt_q) ? cnt_q : cnt_inc[TW-1:0];
          // Timeout fires on the edge where the count reaches the limit
          if (cnt_inc >= TIMEOUT_L) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign sel      = sel_q;
  assign tx_start = (state_q == ST_LOAD);
  assign ack      = tx_start ? (NSRC'(1) << sel_q) : '0;
  assign active   = (state_q != ST_IDLE);
  assign err      = err_q;

endmodule

// File: tb/tb_tx_byte_sched.sv
// tb/tb_tx_byte_sched.sv - directed self-checking bench for tx_byte_sched
module tb_tx_byte_sched;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic       tx_busy;
  logic [2:0] sel;
  logic       tx_start;
  logic [7:0] ack;
  logic       active;
  logic       err;

  int checks = 0;
  int errors = 0;

  tx_byte_sched #(.BUSY_TIMEOUT(255), .TW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .req      (req),
    .tx_busy  (tx_busy),
    .sel      (sel),
    .tx_start (tx_start),
    .ack      (ack),
    .active   (active),
    .err      (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    en      = 1'b1;
    req     = 8'h00;
    tx_busy = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Waits for tx_start, returns the number of cycles taken
  task automatic wait_start(input string tag, input int max, output int n);
    n = 0;
    while (!tx_start && n < max) begin
      tick();
      n++;
    end
    chk({tag, "_start_seen"}, 32'(tx_start), 32'd1);
  endtask

  // Checks the grant in LOAD, then plays a UART busy for busy_len cycles
  task automatic serve(input string tag, input logic [2:0] exp_sel, input int busy_len);
    logic [7:0] exp_ack;
    exp_ack = 8'd1 << exp_sel;
    chk({tag, "_sel"}, 32'(sel), 32'(exp_sel));
    chk({tag, "_ack"}, 32'(ack), 32'(exp_ack));
    tx_busy = 1'b1;
    tick();
    chk({tag, "_start_low"}, 32'(tx_start), 32'd0);
    for (int i = 0; i < busy_len; i++) tick();
    chk({tag, "_ack_low"}, 32'(ack), 32'd0);
    chk({tag, "_sel_hold"}, 32'(sel), 32'(exp_sel));
    chk({tag, "_active_busy"}, 32'(active), 32'd1);
    tx_busy = 1'b0;
    tick();
    chk({tag, "_idle"}, 32'(active), 32'd0);
  endtask

  initial begin
    int n;
    int pulses;
    logic [2:0] exp_s;

    // Reset state
    rst = 1'b1; en = 1'b0; req = 8'h00; tx_busy = 1'b0;
    #12;
    chk("rst_outputs", {19'd0, sel, tx_start, ack, active, err}, 32'd0);
    tick();
    rst = 1'b0;

    // Single source, 10-cycle UART busy; req dropped after LOAD must not abort
    en = 1'b1; req = 8'h01;
    chk("t1_pre_start", 32'(tx_start), 32'd0);
    wait_start("t1", 4, n);
    chk("t1_latency", 32'(n), 32'd1);
    chk("t1_active", 32'(active), 32'd1);
    req = 8'h00;
    serve("t1", 3'd0, 10);

    // Round robin over all sources with wrap
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      exp_s = 3'(k);
      wait_start("t2", 4, n);
      chk("t2_latency", 32'(n), 32'd1);
      serve("t2", exp_s, 2);
    end

    // Search wraps from ptr=7
    do_reset();
    req = 8'h60;
    wait_start("t3a", 4, n);
    serve("t3a", 3'd5, 1);
    wait_start("t3b", 4, n);
    serve("t3b", 3'd6, 1);
    req = 8'h21;
    wait_start("t3c", 4, n);
    serve("t3c", 3'd0, 1);
    wait_start("t3d", 4, n);
    serve("t3d", 3'd5, 1);

    // Busy high in IDLE blocks grants
    do_reset();
    tx_busy = 1'b1; req = 8'h01;
    for (int i = 0; i < 3; i++) tick();
    chk("t4_blocked", {30'd0, tx_start, active}, 32'd0);
    tx_busy = 1'b0;
    wait_start("t4", 4, n);
    chk("t4_latency", 32'(n), 32'd1);
    req = 8'h00;
    serve("t4", 3'd0, 1);

    // Busy timeout: err exactly once, 256 cycles after tx_start
    do_reset();
    req = 8'h01;
    wait_start("t5", 4, n);
    req = 8'h00;
    pulses = 0;
    for (int k = 1; k <= 260; k++) begin
      tick();
      if (err) pulses++;
      if (k == 255) chk("t5_err_early", {30'd0, err, active}, 32'd1);
      if (k == 256) chk("t5_err_pulse", {30'd0, err, active}, 32'd2);
      if (k == 257) chk("t5_err_after", {30'd0, err, active}, 32'd0);
    end
    chk("t5_err_count", 32'(pulses), 32'd1);

    // en dropped during WAIT_DONE
    do_reset();
    req = 8'h0F;
    wait_start("t6", 4, n);
    chk("t6_sel", 32'(sel), 32'd0);
    tx_busy = 1'b1;
    tick();
    tick();
    en = 1'b0;
    tick(); tick(); tick();
    chk("t6_active_mid", 32'(active), 32'd1);
    tx_busy = 1'b0;
    tick();
    chk("t6_idle", 32'(active), 32'd0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_start || active) pulses++;
    end
    chk("t6_no_start", 32'(pulses), 32'd0);
    en = 1'b1;
    wait_start("t6r", 4, n);
    req = 8'h00;
    serve("t6r", 3'd1, 1);

    // Reset in WAIT_BUSY abandons the transfer
    do_reset();
    req = 8'h04;
    wait_start("t7", 4, n);
    chk("t7_sel", 32'(sel), 32'd2);
    tick();
    rst = 1'b1;
    #1;
    chk("t7_async_clear", {19'd0, sel, tx_start, ack, active, err}, 32'd0);
    tick();
    rst = 1'b0;
    req = 8'hFF;
    wait_start("t7r", 4, n);
    chk("t7r_latency", 32'(n), 32'd1);
    req = 8'h00;
    serve("t7r", 3'd0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
